autoscale_restore: RTL and testbench
====================================

Name: autoscale_restore

Overview:
- Inverse of the autoscale stage in the FRB detection datapath.
- Autoscale left-shifts a sample pair and reports the shift it applied. That pair then passes through a long processing chain (e.g. CORDIC magnitude/phase) whose latency is not fixed.
- This block queues each reported shift in a tag FIFO. When the processed sample returns, it pops the matching shift and applies a rounded right-shift to restore the original scale.
- It sits directly after the processing chain and before the accumulators.

Parameters:
- DIN_WIDTH, 32, width of the processed sample and of the restored output
- SHIFT_WIDTH, 5, stored shift width; must hold MAX_SHIFT
- MAX_SHIFT, 10, upper clamp; must equal the upstream autoscale setting
- MIN_SHIFT, 3, shifts below this were not applied upstream and restore as 0
- FIFO_DEPTH, 16, shift-tag entries; power of two

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; when low, all state holds
- clear  in  1  synchronous: empties FIFO, clears sticky flags
- shift_in  in  32  shift value reported by autoscale; low SHIFT_WIDTH bits used
- shift_valid  in  1  push shift_in into the tag FIFO
- din  in  DIN_WIDTH  processed unsigned sample
- din_valid  in  1  sample valid; pops one tag
- dout  out  DIN_WIDTH  restored sample
- dout_valid  out  1  dout valid
- shift_used  out  SHIFT_WIDTH  effective shift applied to the current dout
- fifo_count  out  $clog2(FIFO_DEPTH)+1  tags held
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- underflow  out  1  sticky: a pop hit an empty FIFO

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout, dout_valid, shift_used, fifo_count, overflow and underflow all go to 0.
  - Read and write pointers go to 0.
  - FIFO storage contents are don't-care.
- ce low: no push, no pop, no pipeline advance. Outputs hold their values, including dout_valid.
- All events below are qualified by ce=1.
- Push: shift_valid=1 and not full writes shift_in[SHIFT_WIDTH-1:0]. fifo_count increments.
- Pop: din_valid=1 and not empty reads the oldest tag. fifo_count decrements.
- Simultaneous push and pop, FIFO non-empty: both happen. fifo_count is unchanged. Pop returns the oldest tag.
- Simultaneous push and pop, FIFO empty: bypass. The incoming shift_in is used directly and nothing is stored. fifo_count stays 0. underflow is not set.
- Push while full with no pop: the push is dropped, overflow is set, and the contents are unchanged.
- Push while full with a simultaneous pop: both happen and overflow is not set.
- Pop while empty with no push: the tag is treated as 0 and underflow is set. The sample still flows through and dout equals din.
- clear: takes priority over push and pop in the same cycle. Pointers, fifo_count and the sticky flags go to 0. Samples already in the pipeline complete normally.
- Effective shift s, computed from the raw tag t:
  - t > MAX_SHIFT gives s = MAX_SHIFT.
  - t < MIN_SHIFT gives s = 0.
  - Otherwise s = t.
  - This clamping matches the upstream autoscale rule exactly.
- Arithmetic:
  - s = 0: dout = din.
  - s > 0: dout = (din + 2^(s-1)) >> s, computed in DIN_WIDTH+1 bits. This is round-half-up.
  - The result always fits in DIN_WIDTH bits, so no saturation is needed.
- Pipeline, fixed latency of 2 cycles from din_valid to dout_valid:
  - Stage 1 registers din, performs the pop and registers s.
  - Stage 2 registers dout, shift_used and dout_valid.
  - Back-to-back valid samples are accepted every cycle.
- din_valid=0 produces dout_valid=0 two cycles later. dout and shift_used hold their last values.
- Pointer wrap-around: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty state comes from fifo_count.

Decomposition:
- Shared package:
  - clamp constants MAX_SHIFT and MIN_SHIFT, so this block and the upstream autoscale use one definition
  - SHIFT_WIDTH
  - a function computing the effective shift from a raw tag
- Sub-module shift_tag_fifo:
  - synchronous-write / registered-read FIFO with count, full, empty and bypass
  - used once in this block; reusable for other tag-alignment needs

Test Plan:
- Push tag 5; two cycles later din=0x000003F0 with din_valid -> dout=0x00000020, shift_used=5, dout_valid exactly 2 cycles after din_valid, fifo_count back to 0.
- Push tags 12, 2, 3, then 3 samples of din=0x00001000 -> dout=0x00000004 (s=10), 0x00001000 (s=0), 0x00000200 (s=3), in order.
- Push 17 tags with no pops -> fifo_count=16, overflow=1. The first 16 tags pop in order; the 17th is absent. clear -> overflow=0, fifo_count=0.
- din_valid=1 with FIFO empty and shift_valid=0, din=0xDEADBEEF -> dout=0xDEADBEEF, shift_used=0, underflow=1.
- Same-cycle shift_valid=1 (tag 4) and din_valid=1 on an empty FIFO, din=0x00000018 -> dout=0x00000002, underflow=0, fifo_count=0.
- Stream 8 samples with ce toggled every other cycle; assert rst_n low mid-stream -> outputs hold while ce=0, and all outputs and flags read 0 immediately on rst_n low without waiting for a clock edge.

Source files
------------

// File: rtl/autoscale_restore_pkg.sv
// autoscale_restore_pkg: shift-clamp constants and effective-shift rule shared with the upstream autoscale stage.
// Contents: SHIFT_WIDTH, MAX_SHIFT, MIN_SHIFT, eff_shift(tag, max_s, min_s).
package autoscale_restore_pkg;
    localparam int SHIFT_WIDTH = 5;
    localparam int MAX_SHIFT = 10;
    localparam int MIN_SHIFT = 3;
    // Shifts above the clamp saturate; shifts below the floor were never applied upstream.
    function automatic int eff_shift(input int tag, input int max_s, input int min_s);
        return tag > max_s ? max_s : (tag < min_s ? 0 : tag);
    endfunction
endpackage

// File: rtl/autoscale_restore_shift_tag_fifo.sv
// shift_tag_fifo: tag FIFO with synchronous write, registered read, count, full/empty, empty-FIFO bypass and sticky error flags.
// Ports: clk, rst_n (async low), ce, clear | wr_en, wr_data -> push | rd_en -> pop into rd_data |
//        count, full, empty | overflow (dropped push), underflow (pop on empty without bypass).
module shift_tag_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic bypass, do_push, do_pop;
    always_comb begin
        full = count == CW'(DEPTH);
        empty = count == '0;
        bypass = wr_en && rd_en && empty;
        do_pop = rd_en && !empty;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        do_push = wr_en && !bypass && (!full || rd_en);
    end
    always_ff @(posedge clk)
        if (ce && !clear && do_push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_data <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else if (ce) begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                overflow <= 1'b0;
                underflow <= 1'b0;
                if (rd_en) rd_data <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(do_push) - CW'(do_pop);
                if (rd_en) rd_data <= do_pop ? mem[rd_ptr] : (bypass ? wr_data : '0);
                if (wr_en && full && !rd_en) overflow <= 1'b1;
                if (rd_en && empty && !wr_en) underflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/autoscale_restore.sv
// autoscale_restore: pairs each returning sample with its queued autoscale shift and applies a rounded right shift.
// Ports: clk, rst_n (async low), ce, clear | shift_in, shift_valid -> tag push | din, din_valid -> sample in (pops a tag) |
//        dout, dout_valid, shift_used (2-cycle latency) | fifo_count, overflow, underflow.
module autoscale_restore #(
    parameter int DIN_WIDTH = 32,
    parameter int SHIFT_WIDTH = autoscale_restore_pkg::SHIFT_WIDTH,
    parameter int MAX_SHIFT = autoscale_restore_pkg::MAX_SHIFT,
    parameter int MIN_SHIFT = autoscale_restore_pkg::MIN_SHIFT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic                           clear,
    input  logic [31:0]                    shift_in,
    input  logic                           shift_valid,
    input  logic [DIN_WIDTH-1:0]           din,
    input  logic                           din_valid,
    output logic [DIN_WIDTH-1:0]           dout,
    output logic                           dout_valid,
    output logic [SHIFT_WIDTH-1:0]         shift_used,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    output logic                           underflow
);
    import autoscale_restore_pkg::*;
    logic [SHIFT_WIDTH-1:0] tag, s;
    logic [DIN_WIDTH-1:0] d1;
    logic v1;
    logic [DIN_WIDTH:0] rnd, shifted;
    logic fifo_full, fifo_empty;
    logic unused;
    assign unused = ^{shift_in[31:SHIFT_WIDTH], fifo_full, fifo_empty, shifted[DIN_WIDTH]};
    // Stage 1 of the pipeline: the FIFO registers the popped (or bypassed) tag alongside d1/v1.
    shift_tag_fifo #(.WIDTH(SHIFT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .clear(clear),
        .wr_en(shift_valid),
        .wr_data(shift_in[SHIFT_WIDTH-1:0]),
        .rd_en(din_valid),
        .rd_data(tag),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty),
        .overflow(overflow),
        .underflow(underflow)
    );
    // One extra bit holds the carry of the rounding add; the shifted result always fits DIN_WIDTH.
    always_comb begin
        s = SHIFT_WIDTH'(eff_shift(int'(tag), MAX_SHIFT, MIN_SHIFT));
        rnd = s == '0 ? '0 : ((DIN_WIDTH+1)'(1) << (s - SHIFT_WIDTH'(1)));
        shifted = ({1'b0, d1} + rnd) >> s;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
            shift_used <= '0;
        end else if (ce) begin
            v1 <= din_valid;
            d1 <= din;
            dout_valid <= v1;
            if (v1) begin
                dout <= shifted[DIN_WIDTH-1:0];
                shift_used <= s;
            end
        end
    end
endmodule

// File: tb/tb_autoscale_restore.sv
// tb_autoscale_restore: directed and randomized checks of autoscale_restore against a queue-based reference model.
module tb_autoscale_restore;
    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, clear = 1'b0, shift_valid = 1'b0, din_valid = 1'b0;
    logic [31:0] shift_in = '0, din = '0, dout;
    logic dout_valid, overflow, underflow;
    logic [4:0] shift_used, fifo_count;
    int errors = 0, checks = 0;
    int q[$];
    bit m_ovf, m_unf, p_v, o_v;
    longint p_d, o_d;
    int p_s, o_s;

    always #5 clk = ~clk;

    autoscale_restore dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clear(clear),
        .shift_in(shift_in), .shift_valid(shift_valid),
        .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .shift_used(shift_used),
        .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
    );

    function automatic int clampf(int t);
        if (t > 10) return 10;
        if (t < 3) return 0;
        return t;
    endfunction

    function automatic longint restore(longint x, int s);
        if (s == 0) return x;
        return (x + 2 ** (s - 1)) / (2 ** s);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0;
        p_v = 0; p_d = 0; p_s = 0;
        o_v = 0; o_d = 0; o_s = 0;
    endtask

    task automatic model_edge();
        int t;
        t = 0;
        if (clear) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (din_valid) begin
            if (q.size() > 0) begin
                t = q.pop_front();
                if (shift_valid) q.push_back(int'(shift_in[4:0]));
            end else if (shift_valid) t = int'(shift_in[4:0]);
            else m_unf = 1;
        end else if (shift_valid) begin
            if (q.size() < 16) q.push_back(int'(shift_in[4:0]));
            else m_ovf = 1;
        end
        if (p_v) begin
            o_d = p_d;
            o_s = p_s;
        end
        o_v = p_v;
        p_v = din_valid;
        if (din_valid) begin
            p_s = clampf(t);
            p_d = restore(longint'(din), p_s);
        end
    endtask

    task automatic check_all();
        chk("dout", dout, o_d);
        chk("dout_valid", dout_valid, o_v);
        chk("shift_used", shift_used, o_s);
        chk("fifo_count", fifo_count, q.size());
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    task automatic step(bit c, bit sv, int sh, bit dv, logic [31:0] d, bit clr = 0);
        ce = c; shift_valid = sv; shift_in = sh; din_valid = dv; din = d; clear = clr;
        @(posedge clk);
        if (c) model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // single tag, latency and rounding
        step(1, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h000003F0);
        chk("t1_lat", dout_valid, 0);
        step(1, 0, 0, 0, 0);
        chk("t1_dout", dout, 32'h20);
        chk("t1_shift", shift_used, 5);
        chk("t1_valid", dout_valid, 1);
        chk("t1_count", fifo_count, 0);

        // clamp high, clamp low, in-range
        step(1, 1, 12, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 3, 0, 0);
        step(1, 0, 0, 1, 32'h1000);
        step(1, 0, 0, 1, 32'h1000);
        chk("t2_a", dout, 32'h4);
        step(1, 0, 0, 1, 32'h1000);
        chk("t2_b", dout, 32'h1000);
        step(1, 0, 0, 0, 0);
        chk("t2_c", dout, 32'h200);

        // overflow, ordered drain, clear
        for (int i = 0; i < 17; i++) step(1, 1, i, 0, 0);
        chk("t3_count", fifo_count, 16);
        chk("t3_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 32'h0001_0000 + i);
        step(1, 0, 0, 1, 32'h0000_0123);
        chk("t3_unf", underflow, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("t3_clr_ovf", overflow, 0);
        chk("t3_clr_cnt", fifo_count, 0);

        // underflow passes the sample unchanged
        step(1, 0, 0, 1, 32'hDEADBEEF);
        step(1, 0, 0, 0, 0);
        chk("t4_dout", dout, 32'hDEADBEEF);
        chk("t4_shift", shift_used, 0);
        chk("t4_unf", underflow, 1);
        step(1, 0, 0, 0, 0, 1);

        // bypass on empty FIFO
        step(1, 1, 4, 1, 32'h18);
        step(1, 0, 0, 0, 0);
        chk("t5_dout", dout, 32'h2);
        chk("t5_unf", underflow, 0);
        chk("t5_count", fifo_count, 0);

        // ce toggling stream, then async reset mid-stream
        for (int i = 0; i < 8; i++) step(1, 1, 3 + i, 0, 0);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 0, 0, 1, 32'h0000_8000 + 32'(i * 77));
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_dout", dout, 0);
        #1 rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                 $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 39) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
